// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the rv_fetch_unit instruction-fetch stage.
package rv_fetch_pkg;

    localparam int unsigned FETCH_PC_W = 11;
    localparam logic [6:0]  OPC_HALT   = 7'h7F;
    localparam int unsigned PC_INC     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_if.sv
// Fetch-stage bus: instruction-memory port, datapath handshake and redirect.
// Optional fetch_misalign signal exists only with FETCH_MISALIGN_TRAP_EN defined.
interface rv_fetch_if
    import rv_fetch_pkg::*;
#(
    parameter int unsigned PC_W = FETCH_PC_W
);
    logic            imem_en;
    logic [PC_W-3:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            run;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misalign;
`endif

    modport master (
        output imem_en, imem_addr, instr, instr_pc, instr_valid, run,
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misalign,
`endif
        input  imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, instr, instr_pc, instr_valid, run,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misalign,
`endif
        output imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// Two-entry registered-output FIFO of fetch entries; flush overrides push.
module rv_fetch_queue
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);
    fetch_entry_t ent0_q, ent1_q;
    logic [1:0]   count_q;
    logic         pop_ok;

    assign pop_ok = pop_i && (count_q != 2'd0);

    // ent0_q is always the head, so the output is a plain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({push_i, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_q  <= din_i;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        ent1_q  <= din_i;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0_q  <= ent1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_q <= din_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch stage: issues word reads, buffers responses, handles redirect/halt.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = FETCH_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      HALT_OPC = OPC_HALT
) (
    input logic        CLOCK_50,
    input logic        rst_n,
    rv_fetch_if.master bus
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
    logic            epoch_q, epoch_d, tag_q, inflight_q, run_q;
    logic            issue, pop, push, flush, redirect, halt_hit;
    logic [2:0]      occupancy;
    logic [1:0]      q_count;
    logic            q_full, q_empty;
    fetch_entry_t    q_din, q_head;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    assign pop       = !q_empty && bus.instr_ready;
    assign push      = inflight_q && (tag_q == epoch_q) && (state_q == FETCH);
    assign redirect  = (state_q == FETCH) && bus.redirect_valid;
    assign halt_hit  = pop && (q_head.instr[6:0] == HALT_OPC);
    // Slots committed after this cycle: queued minus popped plus the read in flight.
    assign occupancy = {1'b0, q_count} - {2'b00, pop} + {2'b00, inflight_q};
    assign q_din     = '{instr: bus.imem_rdata, pc: req_pc_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        issue      = 1'b0;
        flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        epoch_d    = ~epoch_q;
                        fetch_pc_d = bus.redirect_pc;
                    end
`else
                    epoch_d    = ~epoch_q;
                    fetch_pc_d = bus.redirect_pc & ~PC_W'(3);
`endif
                end else if (halt_hit) begin
                    flush   = 1'b1;
                    state_d = HALT;
                end else if ((occupancy < 3'd2) && !(q_full && !pop)) begin
                    issue      = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            epoch_q    <= 1'b0;
            tag_q      <= 1'b0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= issue;
            run_q      <= (state_d == FETCH);
            if (issue) begin
                req_pc_q <= fetch_pc_q;
                tag_q    <= epoch_q;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign bus.fetch_misalign = misalign_q;
`endif

    rv_fetch_queue u_queue (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (q_din),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = fetch_pc_q[PC_W-1:2];
    assign bus.instr       = q_head.instr;
    assign bus.instr_pc    = q_head.pc;
    assign bus.instr_valid = !q_empty;
    assign bus.run         = run_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit: per-cycle vector table plus handshake scoreboard.
module tb_rv_fetch_unit;
    import rv_fetch_pkg::*;

    typedef struct {
        logic        ready;
        logic        rv;
        logic [10:0] rpc;
        logic        v;
        logic [10:0] pc;
        logic        en;
        logic        run;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_b_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [512];
    logic [10:0] sb [$];
    vec_t        tbl [23];

    rv_fetch_if #(.PC_W(11)) bus_a ();
    rv_fetch_if #(.PC_W(11)) bus_b ();

    rv_fetch_unit #(.PC_W(11), .RESET_PC(11'h000), .HALT_OPC(7'h7F)) dut_a (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus_a)
    );

    rv_fetch_unit #(.PC_W(11), .RESET_PC(11'h7F8), .HALT_OPC(7'h7F)) dut_b (
        .CLOCK_50 (clk),
        .rst_n    (rst_b_n),
        .bus      (bus_b)
    );

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (bus_a.imem_en) bus_a.imem_rdata <= mem[bus_a.imem_addr];
        if (bus_b.imem_en) bus_b.imem_rdata <= mem[bus_b.imem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ready, input logic rv, input logic [10:0] rpc);
        bus_a.instr_ready    = ready;
        bus_a.redirect_valid = rv;
        bus_a.redirect_pc    = rpc;
    endtask

    task automatic chk_cyc(input string name, input logic v, input logic [10:0] pc,
                           input logic en, input logic run);
        chk({name, "_valid"}, 64'(bus_a.instr_valid), 64'(v));
        chk({name, "_en"},    64'(bus_a.imem_en),     64'(en));
        chk({name, "_run"},   64'(bus_a.run),         64'(run));
        if (v) begin
            chk({name, "_pc"},    64'(bus_a.instr_pc), 64'(pc));
            chk({name, "_instr"}, 64'(bus_a.instr),    64'(mem[pc[10:2]]));
        end
    endtask

    // Holds reset two cycles, checks reset outputs, releases; returns at the start of the IDLE cycle.
    task automatic do_reset_a();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 11'h000);
        tick();
        tick();
        @(negedge clk);
        chk("rst_instr", 64'(bus_a.instr), 64'h0);
        chk("rst_pc",    64'(bus_a.instr_pc), 64'h0);
        chk_cyc("rst", 1'b0, 11'h000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic ready, input logic rv, input logic [10:0] rpc,
                                input logic v, input logic [10:0] pc, input logic en, input logic run);
        vec_t r;
        r.ready = ready; r.rv = rv; r.rpc = rpc;
        r.v = v; r.pc = pc; r.en = en; r.run = run;
        return r;
    endfunction

    // Scoreboard: every handshake must match the next expected PC in order.
    always @(negedge clk) begin
        if (rst_n && bus_a.instr_valid && bus_a.instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0h expected no handshake", bus_a.instr_pc);
            end else begin
                logic [10:0] epc;
                epc = sb.pop_front();
                chk("sb_pc",    64'(bus_a.instr_pc), 64'(epc));
                chk("sb_instr", 64'(bus_a.instr),    64'(mem[epc[10:2]]));
            end
        end
    end

    initial begin
        for (int unsigned i = 0; i < 512; i++)
            mem[i] = {i[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
        mem[0]  = 32'h00500293;
        mem[1]  = 32'h00c000ef;
        mem[10] = 32'h0000007f;

        // Stall then run into the halt word at 0x28; a later redirect must be ignored.
        tbl[0]  = mk(1, 0, 11'h000, 0, 11'h000, 0, 0);
        tbl[1]  = mk(1, 0, 11'h000, 0, 11'h000, 1, 1);
        tbl[2]  = mk(1, 0, 11'h000, 0, 11'h000, 1, 1);
        tbl[3]  = mk(1, 0, 11'h000, 1, 11'h000, 1, 1);
        tbl[4]  = mk(1, 0, 11'h000, 1, 11'h004, 1, 1);
        tbl[5]  = mk(0, 0, 11'h000, 1, 11'h008, 0, 1);
        tbl[6]  = mk(0, 0, 11'h000, 1, 11'h008, 0, 1);
        tbl[7]  = mk(0, 0, 11'h000, 1, 11'h008, 0, 1);
        tbl[8]  = mk(0, 0, 11'h000, 1, 11'h008, 0, 1);
        tbl[9]  = mk(0, 0, 11'h000, 1, 11'h008, 0, 1);
        tbl[10] = mk(1, 0, 11'h000, 1, 11'h008, 1, 1);
        tbl[11] = mk(1, 0, 11'h000, 1, 11'h00C, 1, 1);
        tbl[12] = mk(1, 0, 11'h000, 1, 11'h010, 1, 1);
        tbl[13] = mk(1, 0, 11'h000, 1, 11'h014, 1, 1);
        tbl[14] = mk(1, 0, 11'h000, 1, 11'h018, 1, 1);
        tbl[15] = mk(1, 0, 11'h000, 1, 11'h01C, 1, 1);
        tbl[16] = mk(1, 0, 11'h000, 1, 11'h020, 1, 1);
        tbl[17] = mk(1, 0, 11'h000, 1, 11'h024, 1, 1);
        tbl[18] = mk(1, 0, 11'h000, 1, 11'h028, 0, 1);
        tbl[19] = mk(1, 0, 11'h000, 0, 11'h000, 0, 0);
        tbl[20] = mk(1, 1, 11'h010, 0, 11'h000, 0, 0);
        tbl[21] = mk(1, 0, 11'h000, 0, 11'h000, 0, 0);
        tbl[22] = mk(1, 0, 11'h000, 0, 11'h000, 0, 0);

        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        drive(1'b0, 1'b0, 11'h000);
        bus_b.instr_ready    = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = 11'h000;

        // Sequential fetch then redirect to 0x010 at the handshake of pc 0x004.
        do_reset_a();
        sb.push_back(11'h000); sb.push_back(11'h004);
        sb.push_back(11'h010); sb.push_back(11'h014);
        drive(1'b1, 1'b0, 11'h000);
        @(negedge clk); chk_cyc("rd_c0", 0, 11'h000, 0, 0);
        tick(); @(negedge clk); chk_cyc("rd_c1", 0, 11'h000, 1, 1);
        chk("rd_c1_addr", 64'(bus_a.imem_addr), 64'h0);
        tick(); @(negedge clk); chk_cyc("rd_c2", 0, 11'h000, 1, 1);
        chk("rd_c2_addr", 64'(bus_a.imem_addr), 64'h1);
        tick(); @(negedge clk); chk_cyc("rd_c3", 1, 11'h000, 1, 1);
        tick(); drive(1'b1, 1'b1, 11'h010);
        @(negedge clk); chk_cyc("rd_c4", 1, 11'h004, 0, 1);
        tick(); drive(1'b1, 1'b0, 11'h000);
        @(negedge clk); chk_cyc("rd_c5", 0, 11'h000, 1, 1);
        chk("rd_c5_addr", 64'(bus_a.imem_addr), 64'h4);
        tick(); @(negedge clk); chk_cyc("rd_c6", 0, 11'h000, 1, 1);
        tick(); @(negedge clk); chk_cyc("rd_c7", 1, 11'h010, 1, 1);
        tick(); @(negedge clk); chk_cyc("rd_c8", 1, 11'h014, 1, 1);
        tick(); drive(1'b0, 1'b0, 11'h000);
        chk("rd_sb_drained", 64'(sb.size()), 64'h0);

        // Table: stall at 0x008, release, run to halt, ignored redirect.
        do_reset_a();
        for (int unsigned r = 0; r < 23; r++) begin
            if (r != 0) tick();
            drive(tbl[r].ready, tbl[r].rv, tbl[r].rpc);
            if (tbl[r].ready && tbl[r].v) sb.push_back(tbl[r].pc);
            @(negedge clk);
            chk_cyc($sformatf("tbl%0d", r), tbl[r].v, tbl[r].pc, tbl[r].en, tbl[r].run);
        end
        tick(); drive(1'b0, 1'b0, 11'h000);
        chk("tbl_sb_drained", 64'(sb.size()), 64'h0);

        // Asynchronous reset while stalled with two queued entries.
        do_reset_a();
        drive(1'b0, 1'b0, 11'h000);
        @(negedge clk);
        for (int unsigned c = 1; c < 5; c++) begin
            tick();
            @(negedge clk);
        end
        chk_cyc("mr_pre", 1, 11'h000, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_instr", 64'(bus_a.instr), 64'h0);
        chk("mr_pc",    64'(bus_a.instr_pc), 64'h0);
        chk_cyc("mr_async", 0, 11'h000, 0, 0);
        do_reset_a();
        sb.push_back(11'h000); sb.push_back(11'h004); sb.push_back(11'h008);
        drive(1'b1, 1'b0, 11'h000);
        @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk); chk_cyc("mr_c2", 0, 11'h000, 1, 1);
        tick(); @(negedge clk); chk_cyc("mr_c3", 1, 11'h000, 1, 1);
        tick(); @(negedge clk); chk_cyc("mr_c4", 1, 11'h004, 1, 1);
        tick(); @(negedge clk); chk_cyc("mr_c5", 1, 11'h008, 1, 1);
        tick(); drive(1'b0, 1'b0, 11'h000);
        chk("mr_sb_drained", 64'(sb.size()), 64'h0);

        // PC wrap on the second instance (RESET_PC = 0x7F8).
        bus_b.instr_ready = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("wr_c0_run", 64'(bus_b.run), 64'h0);
        tick(); @(negedge clk);
        chk("wr_c1_addr", 64'(bus_b.imem_addr), 64'h1FE);
        tick(); @(negedge clk);
        chk("wr_c2_valid", 64'(bus_b.instr_valid), 64'h0);
        tick(); @(negedge clk);
        chk("wr_c3_valid", 64'(bus_b.instr_valid), 64'h1);
        chk("wr_c3_pc",    64'(bus_b.instr_pc), 64'h7F8);
        chk("wr_c3_instr", 64'(bus_b.instr), 64'(mem[510]));
        tick(); @(negedge clk);
        chk("wr_c4_pc",    64'(bus_b.instr_pc), 64'h7FC);
        chk("wr_c4_instr", 64'(bus_b.instr), 64'(mem[511]));
        tick(); @(negedge clk);
        chk("wr_c5_pc",    64'(bus_b.instr_pc), 64'h000);
        chk("wr_c5_instr", 64'(bus_b.instr), 64'(mem[0]));
        chk("wr_c5_valid", 64'(bus_b.instr_valid), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the lab05 RISC-V datapath.
- Drives a word address into a synchronous instruction ROM/RAM (1-cycle read latency) and buffers returned words in a 2-entry queue.
- Presents {instr, instr_pc} to the datapath with a valid/ready handshake.
- Accepts PC redirects (jal/jalr/branch) from the datapath and halts on the 7'h7F stop opcode.

Parameters:
- PC_W, 11, byte-address width of PC (2 KB instruction space).
- RESET_PC, 11'h000, first fetch address after reset.
- HALT_OPC, 7'h7F, opcode (instr[6:0]) that stops fetch.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  PC_W-2  word address (PC[PC_W-1:2]).
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- instr  out  32  instruction to datapath.
- instr_pc  out  PC_W  byte PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  datapath consumes when valid&&ready.
- redirect_valid  in  1  one-cycle PC redirect request.
- redirect_pc  in  PC_W  redirect target (byte address).
- run  out  1  high while fetching; low in reset/IDLE/HALT.

Behaviour:
- States:
  - IDLE: entered in reset; exactly one cycle after rst_n deasserts, then go to FETCH.
  - FETCH: normal fetching.
  - HALT: terminal; left only via rst_n.
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC, queue empty, in-flight=0, epoch=0.
  - Outputs: instr=0, instr_pc=0, instr_valid=0, imem_en=0, run=0.
  - Reset asserted mid-operation discards everything immediately, including in-flight reads.
- run is registered: 1 iff state==FETCH.
- Issue rule (FETCH only): imem_en=1 when queue_count + inflight < 2 (queue_count counted after this cycle's pop).
  - On issue: imem_addr=fetch_pc[PC_W-1:2]; fetch_pc += 4 modulo 2^PC_W (11'h7FC wraps to 11'h000).
  - Tag each request with the current epoch bit.
- Response: the cycle after an issue, push {imem_rdata, issued pc} into the queue if its tag equals the current epoch; otherwise drop it.
- Output: instr/instr_pc/instr_valid come from the queue head (registered-output FIFO, no combinational path from imem_rdata).
- Latency:
  - First instr_valid appears 3 cycles after rst_n rises: IDLE, issue, data.
  - Steady-state throughput is 1 instr/cycle while instr_ready=1.
- Stall: with instr_ready=0, instr/instr_pc hold stable and instr_valid stays 1. The queue fills to 2 and issue stops; nothing is lost or duplicated.
- Redirect (redirect_valid=1 in FETCH):
  - Flush the queue; instr_valid=0 next cycle.
  - Toggle epoch, so any in-flight response is dropped.
  - fetch_pc=redirect_pc; issue from it on the following cycle.
  - Any pop in the same cycle is still honoured for the datapath, but the queue is emptied regardless.
  - Redirect wins over a same-cycle issue: no issue that cycle.
- Halt:
  - Trigger: an instruction with instr[6:0]==HALT_OPC is handshaked (valid&&ready).
  - Next state HALT; queue flushed, imem_en=0, instr_valid=0, run=0.
  - Redirect in the same cycle as the halt handshake: redirect wins, halt ignored.
  - redirect_valid in HALT or IDLE is ignored.
- redirect_pc[1:0] is ignored (forced 2'b00) unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset) and enters HALT instead of redirecting.
- Undefined: no port; low bits are silently masked as above.

Decomposition:
- Package rv_fetch_pkg:
  - Typedef fetch_state_t {IDLE, FETCH, HALT}.
  - Constant OPC_HALT=7'h7F.
  - Constant PC_INC=4.
  - Struct fetch_entry_t {instr[31:0], pc[PC_W-1:0]}.
- Sub-module rv_fetch_queue: 2-entry FIFO of fetch_entry_t with push/pop/flush, count, full/empty. Simultaneous push+pop at count 2 is legal; flush overrides push.

Test Plan:
- Sequential fetch: imem[0]=00500293, imem[1]=00c000ef, ready=1 -> instr_pc 000,004 on consecutive cycles; first valid 3 cycles after rst_n rise; run=1.
- Redirect: at handshake of 00c000ef (pc 004), pulse redirect_valid with redirect_pc=010 -> next valid instr_pc=010; the word at pc 008 is never presented.
- Stall: hold instr_ready=0 for 5 cycles at pc 008 -> instr/instr_pc stable, imem_en low after queue fills. On release -> 008, 00C, 010 in order, no gaps or duplicates.
- Halt: imem[0x28>>2]=0000007f, handshaked -> run=0 next cycle, instr_valid=0, imem_en stays 0; a later redirect_valid is ignored.
- Wrap: RESET_PC=7F8 -> instr_pc 7F8, 7FC, 000.
- Reset mid-operation: assert rst_n=0 during a stall with 2 queued entries -> outputs zero immediately. After release -> fetch restarts at RESET_PC; stale in-flight data is never presented.
